// File: rtl/mf_trigger_pkg.sv
// Shared types and constants for the matched-filter trigger.
package mf_trigger_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_HOLDOFF  = 2'd2
  } trig_state_e;

  localparam int SCALER_W = 16;

endpackage

// File: rtl/trig_scaler.sv
// Trigger rate scaler: counts triggers over a fixed period and reports the total.
module trig_scaler
  import mf_trigger_pkg::*;
#(
  parameter int SCAL_PERIOD = 1000000
) (
  input  logic                aclk,
  input  logic                arst,
  input  logic                trig_i,
  output logic [SCALER_W-1:0] scaler_o,
  output logic                scaler_valid_o
);

  localparam int PW = (SCAL_PERIOD > 1) ? $clog2(SCAL_PERIOD) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SCAL_PERIOD - 1);

  logic [PW-1:0]       period_cnt;
  logic [SCALER_W-1:0] run_cnt;

  function automatic logic [SCALER_W-1:0] sat_inc(input logic [SCALER_W-1:0] c,
                                                  input logic              inc);
    sat_inc = (inc && (c != '1)) ? c + 1'b1 : c;
  endfunction

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      period_cnt     <= '0;
      run_cnt        <= '0;
      scaler_o       <= '0;
      scaler_valid_o <= 1'b0;
    end else begin
      scaler_valid_o <= 1'b0;
      if (period_cnt == PERIOD_LAST) begin
        // terminal cycle: the trigger present now still belongs to this period
        period_cnt     <= '0;
        scaler_o       <= sat_inc(run_cnt, trig_i);
        scaler_valid_o <= 1'b1;
        run_cnt        <= '0;
      end else begin
        period_cnt <= period_cnt + 1'b1;
        run_cnt    <= sat_inc(run_cnt, trig_i);
      end
    end
  end

endmodule

// File: rtl/mf_trigger.sv
// Threshold trigger on a multi-sample matched-filter stream with holdoff and rate scaler.
module mf_trigger
  import mf_trigger_pkg::*;
#(
  parameter int               NBITS       = 18,
  parameter int               NSAMPS      = 8,
  parameter int               HOLDOFF     = 16,
  parameter int               SCAL_PERIOD = 1000000,
  parameter logic [NBITS-1:0] THRESH_INIT = '1
) (
  input  logic                        aclk,
  input  logic                        arst,
  input  logic [NBITS*NSAMPS-1:0]     data_i,
  input  logic                        enable_i,
  input  logic [NBITS-1:0]            thresh_i,
  input  logic                        thresh_wr_i,
  output logic                        trig_o,
  output logic [$clog2(NSAMPS)-1:0]   trig_idx_o,
  output logic [SCALER_W-1:0]         scaler_o,
  output logic                        scaler_valid_o
);

  localparam int IDX_W  = $clog2(NSAMPS);
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  logic [NSAMPS-1:0][NBITS-1:0] mag_p0;
  logic [NSAMPS-1:0]            exc_p1;
  logic [NBITS-1:0]             thresh_q;
  trig_state_e                  state_p2;
  logic [HOLD_W-1:0]            hold_cnt_p2;

  // |x| kept in NBITS unsigned bits so the most negative code maps to 2^(NBITS-1)
  function automatic logic [NBITS-1:0] magnitude(input logic signed [NBITS-1:0] x);
    logic [NBITS-1:0] ux;
    ux = x;
    magnitude = x[NBITS-1] ? (~ux + 1'b1) : ux;
  endfunction

  function automatic logic [IDX_W-1:0] first_set(input logic [NSAMPS-1:0] v);
    first_set = '0;
    for (int k = NSAMPS - 1; k >= 0; k--)
      if (v[k]) first_set = IDX_W'(k);
  endfunction

  // stage p0 magnitude, stage p1 threshold compare
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      mag_p0   <= '0;
      exc_p1   <= '0;
      thresh_q <= THRESH_INIT;
    end else begin
      for (int k = 0; k < NSAMPS; k++) begin
        mag_p0[k] <= magnitude(data_i[NBITS*k +: NBITS]);
        exc_p1[k] <= (mag_p0[k] > thresh_q);
      end
      if (thresh_wr_i) thresh_q <= thresh_i;
    end
  end

  // stage p2 trigger FSM
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_p2    <= ST_DISABLED;
      trig_o      <= 1'b0;
      trig_idx_o  <= '0;
      hold_cnt_p2 <= '0;
    end else begin
      trig_o <= 1'b0;
      if (!enable_i) begin
        state_p2 <= ST_DISABLED;
      end else begin
        case (state_p2)
          ST_DISABLED: state_p2 <= ST_ARMED;
          ST_ARMED: begin
            if (|exc_p1) begin
              trig_o      <= 1'b1;
              trig_idx_o  <= first_set(exc_p1);
              hold_cnt_p2 <= HOLD_LOAD;
              state_p2    <= (HOLDOFF == 0) ? ST_ARMED : ST_HOLDOFF;
            end
          end
          ST_HOLDOFF: begin
            if (hold_cnt_p2 == '0) state_p2 <= ST_ARMED;
            else hold_cnt_p2 <= hold_cnt_p2 - 1'b1;
          end
          default: state_p2 <= ST_DISABLED;
        endcase
      end
    end
  end

  trig_scaler #(
    .SCAL_PERIOD (SCAL_PERIOD)
  ) u_scaler (
    .aclk           (aclk),
    .arst           (arst),
    .trig_i         (trig_o),
    .scaler_o       (scaler_o),
    .scaler_valid_o (scaler_valid_o)
  );

endmodule

// File: doc/mf_trigger.md
MF_TRIGGER -- requirements
Module: mf_trigger

Interface
REQ-001 SHALL have parameter NBITS, default 18, per-sample width of the matched-filter output (signed, two's complement).
REQ-002 SHALL have parameter NSAMPS, default 8, samples per clock (index 0 earliest, NSAMPS-1 latest).
REQ-003 SHALL have parameter HOLDOFF, default 16, number of clocks after a trigger during which no new trigger fires.
REQ-004 SHALL have parameter SCAL_PERIOD, default 1000000, scaler integration period in clocks.
REQ-005 SHALL have parameter THRESH_INIT, default all-ones (NBITS bits), threshold value after reset.
REQ-006 aclk  input  1  sole clock; all logic on its rising edge.
REQ-007 arst  input  1  reset, asynchronous, active-high.
REQ-008 data_i  input  NBITS*NSAMPS  matched-filter samples; sample k at bits [NBITS*k +: NBITS].
REQ-009 enable_i  input  1  trigger enable, level-sensitive.
REQ-010 thresh_i  input  NBITS  unsigned threshold value.
REQ-011 thresh_wr_i  input  1  one-clock strobe that loads thresh_i.
REQ-012 trig_o  output  1  one-clock trigger pulse.
REQ-013 trig_idx_o  output  $clog2(NSAMPS)  index of the earliest exceeding sample; valid while trig_o is high, held otherwise.
REQ-014 scaler_o  output  16  trigger count of the last completed period.
REQ-015 scaler_valid_o  output  1  one-clock pulse when scaler_o updates.

Function
REQ-016 Stage 1 SHALL register the unsigned magnitude |x| of each sample in NBITS bits; -2^(NBITS-1) SHALL map to 2^(NBITS-1) without wrap.
REQ-017 Stage 2 SHALL register an NSAMPS-bit exceed vector, bit k = (|x_k| > threshold register), strictly greater.
REQ-018 A thresh_wr_i strobe in cycle N SHALL update the threshold register at edge N+1; the stage-2 compare SHALL use the new value from cycle N+1 onward.
REQ-019 Stage 3 SHALL be an FSM with states DISABLED, ARMED, HOLDOFF; data_i in cycle N SHALL produce trig_o in cycle N+3 (fixed 3-clock latency).
REQ-020 DISABLED: trig_o SHALL be 0; move to ARMED when enable_i = 1.
REQ-021 ARMED: a nonzero exceed vector SHALL assert trig_o for one clock, set trig_idx_o to the lowest set bit index, load the holdoff counter with HOLDOFF-1, and move to HOLDOFF.
REQ-022 HOLDOFF: trig_o SHALL be 0; the counter SHALL decrement each clock; at count 0 the FSM SHALL return to ARMED, so the earliest retrigger is HOLDOFF+1 clocks after the previous trig_o.
REQ-023 enable_i = 0 in any state SHALL force DISABLED on the next edge, and no trigger SHALL fire in that cycle.
REQ-024 The scaler period counter SHALL count 0 to SCAL_PERIOD-1 and wrap; on the terminal cycle, scaler_o SHALL take the running count including any trig_o in that cycle, scaler_valid_o SHALL pulse, and the running count SHALL clear to 0.
REQ-025 The running count SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-026 The scaler SHALL keep running while enable_i = 0, counting no triggers.

Reset
REQ-027 During arst, the FSM SHALL be DISABLED, all pipeline registers 0, and the threshold register THRESH_INIT.
REQ-028 During arst, trig_o, trig_idx_o, scaler_o and scaler_valid_o SHALL be 0, and the period and running counters SHALL be 0.
REQ-029 Reset deassertion mid-period SHALL start a fresh period at count 0; the first scaler_valid_o SHALL occur SCAL_PERIOD clocks after release.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the 16-bit scaler width constant.
REQ-031 The scaler (REQ-024 to REQ-026) SHALL be a sub-module named trig_scaler with ports aclk, arst, trig_i, scaler_o, scaler_valid_o.
REQ-032 No DSP or SRL primitives SHALL be used; fabric registers only.

Verification
REQ-033 Threshold 100 written, enable = 1; one data_i block with sample 5 = -101 and all others 0 -> trig_o = 1 exactly 3 clocks later, trig_idx_o = 5.
REQ-034 Sample 2 = +100 (equal to the threshold) -> no trigger; sample 2 = -2^17 with threshold 2^17-1 -> trigger, trig_idx_o = 2.
REQ-035 Samples 3 and 6 both exceed in one block -> one trigger, trig_idx_o = 3; exceed on every clock with HOLDOFF = 16 -> trig_o every 17 clocks.
REQ-036 Exceeding input while enable_i drops mid-HOLDOFF -> trig_o stays 0; enable_i reasserted -> trigger 1 clock after re-entering ARMED.
REQ-037 SCAL_PERIOD = 100, HOLDOFF = 4, continuous exceed -> scaler_o = 20, with scaler_valid_o every 100 clocks; 16-bit saturation checked with HOLDOFF = 0 and a long period -> 16'hFFFF.
REQ-038 arst asserted mid-HOLDOFF and mid-period -> all outputs 0 immediately, threshold = THRESH_INIT, and no trigger until a threshold write.
